offchip_lane_tx: RTL and testbench

//  Transmit end of the off-chip lane link. Takes 64-bit words over valid/ready and serialises each

---
 rtl/offchip_pkg.sv | 30 +++
 rtl/offchip_credit_ctr.sv | 42 ++++
 rtl/offchip_lane_tx.sv | 104 ++++++++++
 tb/tb_offchip_lane_tx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/offchip_pkg.sv
// Shared definitions for the off-chip lane link (transmit and receive ends).
// The beat map in lane_beat() must stay in step with the receiver's reassembly.
package offchip_pkg;

   localparam int LANE_W           = 16;
   localparam int WORD_W           = 64;
   localparam int CREDITS_PER_WORD = 2;

   typedef enum logic [2:0] {
      IDLE,
      B0,
      B1,
      B2,
      B3
   } tx_state_e;

   // Byte-interleaved: beat i carries byte i in the low half and byte i+4 in the high half.
   function automatic logic [LANE_W-1:0] lane_beat(input logic [WORD_W-1:0] word,
                                                   input logic [1:0]        idx);
      logic [LANE_W-1:0] beat;
      case (idx)
         2'd0:    beat = {word[39:32], word[7:0]};
         2'd1:    beat = {word[47:40], word[15:8]};
         2'd2:    beat = {word[55:48], word[23:16]};
         default: beat = {word[63:56], word[31:24]};
      endcase
      return beat;
   endfunction

endpackage

// File: rtl/offchip_credit_ctr.sv
// Credit counter for the far-end buffer: reserve per accepted word, restore in batches,
// saturate at DEPTH with a sticky overflow flag.
module offchip_credit_ctr
   import offchip_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int CREDIT_RET = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         take,
   input  logic                         ret,
   output logic [$clog2(DEPTH+1)-1:0]   credit_cnt,
   output logic                         err_credit_ovf,
   output logic                         can_send
);

   localparam int CNT_W = $clog2(DEPTH+1);

   int nxt;

   always_comb begin
      nxt = int'(credit_cnt);
      if (take) nxt = nxt - CREDITS_PER_WORD;
      if (ret)  nxt = nxt + CREDIT_RET;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_cnt     <= CNT_W'(DEPTH);
         err_credit_ovf <= 1'b0;
      end else if (nxt > DEPTH) begin
         credit_cnt     <= CNT_W'(DEPTH);
         err_credit_ovf <= 1'b1;
      end else begin
         credit_cnt     <= CNT_W'(nxt);
      end
   end

   assign can_send = (int'(credit_cnt) >= CREDITS_PER_WORD);

endmodule

// File: rtl/offchip_lane_tx.sv
// Off-chip lane transmitter: 64-bit words out as four 16-bit beats, paced by far-end credits.
// Optional even parity output link_par when OFFCHIP_TX_PARITY_EN is defined.
module offchip_lane_tx
   import offchip_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int CREDIT_RET = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [63:0]                  in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [15:0]                  link_data,
   output logic                         link_valid,
   output logic                         link_sof,
`ifdef OFFCHIP_TX_PARITY_EN
   output logic                         link_par,
`endif
   input  logic                         credit_ret,
   output logic [$clog2(DEPTH+1)-1:0]   credit_cnt,
   output logic                         err_credit_ovf
);

   tx_state_e         state_p0, state_nxt;
   logic [63:0]       hold_p0;
   logic [63:0]       beat_word;
   logic [1:0]        beat_idx;
   logic [15:0]       beat_nxt;
   logic              valid_nxt;
   logic              can_send;
   logic              accept;

   offchip_credit_ctr #(
      .DEPTH      (DEPTH),
      .CREDIT_RET (CREDIT_RET)
   ) u_credit (
      .clk            (clk),
      .rst_n          (rst_n),
      .take           (accept),
      .ret            (credit_ret),
      .credit_cnt     (credit_cnt),
      .err_credit_ovf (err_credit_ovf),
      .can_send       (can_send)
   );

   assign in_ready = ((state_p0 == IDLE) || (state_p0 == B3)) && can_send;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_nxt = state_p0;
      case (state_p0)
         IDLE:    if (accept) state_nxt = B0;
         B0:      state_nxt = B1;
         B1:      state_nxt = B2;
         B2:      state_nxt = B3;
         B3:      state_nxt = accept ? B0 : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Beat for the coming cycle; on an accept edge the hold register is not yet loaded.
   always_comb begin
      beat_word = accept ? in_data : hold_p0;
      case (state_nxt)
         B1:      beat_idx = 2'd1;
         B2:      beat_idx = 2'd2;
         B3:      beat_idx = 2'd3;
         default: beat_idx = 2'd0;
      endcase
      beat_nxt  = lane_beat(beat_word, beat_idx);
      valid_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_p0 <= IDLE;
      else        state_p0 <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (accept) hold_p0 <= in_data;
   end

   // Output stage: all lane signals registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         link_data  <= '0;
         link_valid <= 1'b0;
         link_sof   <= 1'b0;
      end else begin
         link_data  <= valid_nxt ? beat_nxt : '0;
         link_valid <= valid_nxt;
         link_sof   <= (state_nxt == B0);
      end
   end

`ifdef OFFCHIP_TX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) link_par <= 1'b0;
      else        link_par <= valid_nxt ? ^beat_nxt : 1'b0;
   end
`endif

endmodule

// File: tb/tb_offchip_lane_tx.sv
// Randomized and directed bench for offchip_lane_tx against a queue-based beat/credit model.
// Define OFFCHIP_TX_PARITY_EN to also exercise link_par.
module tb_offchip_lane_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] link_data;
   logic        link_valid;
   logic        link_sof;
`ifdef OFFCHIP_TX_PARITY_EN
   logic        link_par;
`endif
   logic        credit_ret = 1'b0;
   logic [3:0]  credit_cnt;
   logic        err_credit_ovf;

   offchip_lane_tx dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .link_data      (link_data),
      .link_valid     (link_valid),
      .link_sof       (link_sof),
`ifdef OFFCHIP_TX_PARITY_EN
      .link_par       (link_par),
`endif
      .credit_ret     (credit_ret),
      .credit_cnt     (credit_cnt),
      .err_credit_ovf (err_credit_ovf)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: pending beats {sof, data}, credit count and sticky error.
   logic [16:0] exp_q[$];
   int          m_cnt = 8;
   logic        m_err = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] model_beat(input logic [63:0] d, input int i);
      logic [7:0] lo, hi;
      lo = 8'((d >> (8 * i)) & 64'hff);
      hi = 8'((d >> (8 * (i + 4))) & 64'hff);
      return {hi, lo};
   endfunction

   function automatic logic model_ready();
      return (exp_q.size() <= 1) && (m_cnt >= 2);
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_cnt = 8;
      m_err = 1'b0;
   endtask

   // One clock: compare at negedge, drive, then advance the model at posedge.
   task automatic step(input logic v, input logic [63:0] d, input logic r);
      logic acc;
      @(negedge clk);
      chk("in_ready", in_ready, model_ready());
      chk("link_valid", link_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         chk("link_data", link_data, exp_q[0][15:0]);
         chk("link_sof", link_sof, exp_q[0][16]);
`ifdef OFFCHIP_TX_PARITY_EN
         chk("link_par", link_par, ^exp_q[0][15:0]);
`endif
      end else begin
`ifdef OFFCHIP_TX_PARITY_EN
         chk("link_par_idle", link_par, 1'b0);
`endif
      end
      chk("credit_cnt", credit_cnt, m_cnt);
      chk("err_credit_ovf", err_credit_ovf, m_err);
      in_valid   = v;
      in_data    = d;
      credit_ret = r;
      acc = v && model_ready();
      @(posedge clk);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc) begin
         for (int i = 0; i < 4; i++) exp_q.push_back({(i == 0), model_beat(d, i)});
         m_cnt = m_cnt - 2;
      end
      if (r) m_cnt = m_cnt + 4;
      if (m_cnt > 8) begin
         m_cnt = 8;
         m_err = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      credit_ret = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   logic [15:0] beats2 [4] = '{16'h5511, 16'h6622, 16'h7733, 16'h8844};

   initial begin
      // Reset and idle
      do_reset();
      #1;
      chk("rst_credit_cnt", credit_cnt, 4'd8);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_link_valid", link_valid, 1'b0);
      chk("rst_err", err_credit_ovf, 1'b0);
      step(0, rnd64(), 0);

      // Single word with known beat pattern
      step(1, 64'h8877665544332211, 0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("w1_beat", link_data, beats2[i]);
         chk("w1_sof", link_sof, (i == 0));
         chk("w1_cnt", credit_cnt, 4'd6);
         step(0, rnd64(), 0);
      end
      #1;
      chk("w1_done_valid", link_valid, 1'b0);
      repeat (2) step(0, rnd64(), 0);

      // Back-to-back until credits run out, then a return releases the fifth word
      do_reset();
      for (int i = 0; i < 18; i++) step(1, rnd64(), 0);
      #1;
      chk("b2b_cnt_zero", credit_cnt, 4'd0);
      chk("b2b_not_ready", in_ready, 1'b0);
      step(1, rnd64(), 1);
      #1;
      chk("b2b_cnt_ret", credit_cnt, 4'd4);
      for (int i = 0; i < 6; i++) step(1, rnd64(), 0);
      repeat (4) step(0, rnd64(), 0);

      // Accept coinciding with a credit return at count 2
      do_reset();
      for (int i = 0; i < 12; i++) step(1, rnd64(), 0);
      step(1, rnd64(), 1);
      #1;
      chk("coinc_cnt", credit_cnt, 4'd4);
      chk("coinc_err", err_credit_ovf, 1'b0);
      repeat (5) step(0, rnd64(), 0);

      // Overflow is sticky until reset
      do_reset();
      step(0, rnd64(), 1);
      #1;
      chk("ovf_cnt", credit_cnt, 4'd8);
      chk("ovf_err", err_credit_ovf, 1'b1);
      repeat (3) step(1, rnd64(), 0);
      do_reset();
      #1;
      chk("ovf_cleared", err_credit_ovf, 1'b0);

      // Reset asserted mid-word; credit_ret during reset is ignored
      step(1, 64'h0000_0000_0000_0001, 0);
      step(0, rnd64(), 0);
      step(0, rnd64(), 0);
      #2;
      rst_n      = 1'b0;
      credit_ret = 1'b1;
      #1;
      chk("midrst_valid", link_valid, 1'b0);
      chk("midrst_cnt", credit_cnt, 4'd8);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n      = 1'b1;
      credit_ret = 1'b0;
      in_valid   = 1'b0;
      repeat (3) step(0, rnd64(), 0);

      // Parity sample word then randomized traffic
      step(1, 64'h0000_0000_0000_0001, 0);
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 9) < 6), rnd64(), ($urandom_range(0, 7) == 0));
      end
      repeat (6) step(0, rnd64(), 0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
